// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: ordered-set symbol values, symbol positions inside
// a 128-bit training sequence, and the receive-checker FSM state type.
// The TS generator and the receive checker both use these constants.
package ltssm_pkg;

  localparam int unsigned TS_W = 128;

  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] TS1_ID  = 8'h4A;
  localparam logic [7:0] TS2_ID  = 8'h45;

  // Symbol k occupies bits [8k+7:8k]
  localparam int unsigned SYM_COM   = 0;
  localparam int unsigned SYM_LINK  = 1;
  localparam int unsigned SYM_LANE  = 2;
  localparam int unsigned SYM_NFTS  = 3;
  localparam int unsigned SYM_RATE  = 4;
  localparam int unsigned SYM_CTRL  = 5;
  localparam int unsigned SYM_ID_LO = 6;
  localparam int unsigned SYM_ID_HI = 15;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LOCK = 2'd1,
    DONE = 2'd2
  } rx_state_e;

  function automatic logic [7:0] ts_sym(input logic [TS_W-1:0] ts, input int unsigned k);
    return ts[8*k +: 8];
  endfunction

endpackage

// File: rtl/ts_rx_decode.sv
// Combinational TS decoder.
// Ports:
//   ts_i        inbound 128-bit training sequence
//   is_good_o   COM present and identifier symbols 6..15 uniformly TS1 or TS2
//   is_ts2_o    identifiers are all TS2 (only meaningful with is_good_o)
//   key_o       symbols 1..5, used to detect identical consecutive TSs
//   link_num_o, lane_num_o, rate_o, ctrl_o  symbols 1, 2, 4, 5
module ts_rx_decode
  import ltssm_pkg::*;
(
  input  logic [TS_W-1:0] ts_i,
  output logic            is_good_o,
  output logic            is_ts2_o,
  output logic [39:0]     key_o,
  output logic [7:0]      link_num_o,
  output logic [7:0]      lane_num_o,
  output logic [7:0]      rate_o,
  output logic [7:0]      ctrl_o
);

  logic all_ts1;
  logic all_ts2;

  always_comb begin
    all_ts1 = 1'b1;
    all_ts2 = 1'b1;
    for (int unsigned k = SYM_ID_LO; k <= SYM_ID_HI; k++) begin
      if (ts_sym(ts_i, k) != TS1_ID) all_ts1 = 1'b0;
      if (ts_sym(ts_i, k) != TS2_ID) all_ts2 = 1'b0;
    end
  end

  // A mix of TS1 and TS2 identifiers clears both flags and is therefore malformed
  assign is_good_o  = (ts_sym(ts_i, SYM_COM) == COM_SYM) && (all_ts1 || all_ts2);
  assign is_ts2_o   = all_ts2;
  assign key_o      = {ts_sym(ts_i, SYM_CTRL), ts_sym(ts_i, SYM_RATE), ts_sym(ts_i, SYM_NFTS),
                       ts_sym(ts_i, SYM_LANE), ts_sym(ts_i, SYM_LINK)};
  assign link_num_o = ts_sym(ts_i, SYM_LINK);
  assign lane_num_o = ts_sym(ts_i, SYM_LANE);
  assign rate_o     = ts_sym(ts_i, SYM_RATE);
  assign ctrl_o     = ts_sym(ts_i, SYM_CTRL);

endmodule

// File: rtl/ts_rx_chk.sv
// Per-lane receive-side training-sequence checker.
// Validates each inbound TS, classifies TS1/TS2, counts consecutive identical
// expected TSs and flags rcv_enough once RCV_THRESH have been seen.
// Optional build macro: TS_RX_ERR_CNT_EN enables the malformed-TS counter;
// without it err_cnt is tied to 0.
// Ports:
//   clk, rst (async, active-low)
//   ts_i, ts_i_vld   inbound TS and its single-cycle strobe
//   clr              flush count and return to HUNT (wins over a coincident TS)
//   expect_ts2       0: count TS1s, 1: count TS2s
//   rcv_enough       sticky until clr
//   cons_cnt         consecutive identical expected TS count (saturating)
//   ts_is_ts2, rx_link_num, rx_lane_num, rx_rate, rx_ctrl  fields of last good TS
//   err_cnt          malformed TS count
module ts_rx_chk
  import ltssm_pkg::*;
#(
  parameter int unsigned CNT_W      = 5,
  parameter int unsigned RCV_THRESH = 8,
  parameter int unsigned GAP_TO     = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TS_W-1:0]  ts_i,
  input  logic             ts_i_vld,
  input  logic             clr,
  input  logic             expect_ts2,
  output logic             rcv_enough,
  output logic [CNT_W-1:0] cons_cnt,
  output logic             ts_is_ts2,
  output logic [7:0]       rx_link_num,
  output logic [7:0]       rx_lane_num,
  output logic [7:0]       rx_rate,
  output logic [7:0]       rx_ctrl,
  output logic [7:0]       err_cnt
);

  localparam int unsigned      GAP_W    = (GAP_TO > 2) ? $clog2(GAP_TO) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TO - 1);
  localparam logic [CNT_W-1:0] THRESH   = CNT_W'(RCV_THRESH);

  logic        dec_good;
  logic        dec_ts2;
  logic [39:0] dec_key;
  logic [7:0]  dec_link;
  logic [7:0]  dec_lane;
  logic [7:0]  dec_rate;
  logic [7:0]  dec_ctrl;

  ts_rx_decode u_decode (
    .ts_i       (ts_i),
    .is_good_o  (dec_good),
    .is_ts2_o   (dec_ts2),
    .key_o      (dec_key),
    .link_num_o (dec_link),
    .lane_num_o (dec_lane),
    .rate_o     (dec_rate),
    .ctrl_o     (dec_ctrl)
  );

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [39:0]      prev_q, prev_d;
  logic             ts2_q, ts2_d;
  logic [7:0]       link_q, link_d;
  logic [7:0]       lane_q, lane_d;
  logic [7:0]       rate_q, rate_d;
  logic [7:0]       ctrl_q, ctrl_d;

  logic             ts_take;
  logic             ts_good;
  logic             ts_exp;
  logic             ts_ident;
  logic [CNT_W-1:0] cnt_inc;

  // clr drops any coincident TS entirely
  assign ts_take  = ts_i_vld && !clr;
  assign ts_good  = ts_take && dec_good;
  assign ts_exp   = ts_good && (dec_ts2 == expect_ts2);
  assign ts_ident = (dec_key == prev_q);
  assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = '0;
    prev_d  = prev_q;
    ts2_d   = ts2_q;
    link_d  = link_q;
    lane_d  = lane_q;
    rate_d  = rate_q;
    ctrl_d  = ctrl_q;

    if (ts_good) begin
      ts2_d  = dec_ts2;
      link_d = dec_link;
      lane_d = dec_lane;
      rate_d = dec_rate;
      ctrl_d = dec_ctrl;
    end
    if (ts_exp) prev_d = dec_key;

    if (clr) begin
      state_d = HUNT;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        HUNT: begin
          if (ts_exp) begin
            state_d = LOCK;
            cnt_d   = CNT_W'(1);
          end
        end
        LOCK: begin
          if (ts_take) begin
            if (ts_exp && ts_ident) begin
              cnt_d = cnt_inc;
              if (cnt_inc >= THRESH) state_d = DONE;
            end else if (ts_exp) begin
              cnt_d = CNT_W'(1);
            end else begin
              state_d = HUNT;
              cnt_d   = '0;
            end
          end else if (gap_q == GAP_LAST) begin
            state_d = HUNT;
            cnt_d   = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        DONE: ;
        default: begin
          state_d = HUNT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      gap_q   <= '0;
      prev_q  <= '0;
      ts2_q   <= 1'b0;
      link_q  <= '0;
      lane_q  <= '0;
      rate_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      prev_q  <= prev_d;
      ts2_q   <= ts2_d;
      link_q  <= link_d;
      lane_q  <= lane_d;
      rate_q  <= rate_d;
      ctrl_q  <= ctrl_d;
    end
  end

`ifdef TS_RX_ERR_CNT_EN
  logic [7:0] err_q, err_d;

  // Survives clr; only reset clears it
  always_comb begin
    err_d = err_q;
    if (ts_take && !dec_good && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= '0;
    else      err_q <= err_d;
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

  assign rcv_enough  = (state_q == DONE);
  assign cons_cnt    = cnt_q;
  assign ts_is_ts2   = ts2_q;
  assign rx_link_num = link_q;
  assign rx_lane_num = lane_q;
  assign rx_rate     = rate_q;
  assign rx_ctrl     = ctrl_q;

endmodule

// File: tb/tb_ts_rx_chk.sv
// Directed self-checking bench for ts_rx_chk (default parameters).
`timescale 1ns / 1ps
module tb_ts_rx_chk;

`ifdef TS_RX_ERR_CNT_EN
  localparam int unsigned ERR_EN = 1;
`else
  localparam int unsigned ERR_EN = 0;
`endif

  logic         clk;
  logic         rst;
  logic [127:0] ts_i;
  logic         ts_i_vld;
  logic         clr;
  logic         expect_ts2;
  logic         rcv_enough;
  logic [4:0]   cons_cnt;
  logic         ts_is_ts2;
  logic [7:0]   rx_link_num;
  logic [7:0]   rx_lane_num;
  logic [7:0]   rx_rate;
  logic [7:0]   rx_ctrl;
  logic [7:0]   err_cnt;

  int checks = 0;
  int errors = 0;

  ts_rx_chk dut (
    .clk         (clk),
    .rst         (rst),
    .ts_i        (ts_i),
    .ts_i_vld    (ts_i_vld),
    .clr         (clr),
    .expect_ts2  (expect_ts2),
    .rcv_enough  (rcv_enough),
    .cons_cnt    (cons_cnt),
    .ts_is_ts2   (ts_is_ts2),
    .rx_link_num (rx_link_num),
    .rx_lane_num (rx_lane_num),
    .rx_rate     (rx_rate),
    .rx_ctrl     (rx_ctrl),
    .err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [127:0] t);
    ts_i     = t;
    ts_i_vld = 1'b1;
    tick();
    ts_i_vld = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  function automatic logic [127:0] mk_ts(input logic [7:0] com, input logic [7:0] link,
                                         input logic [7:0] lane, input logic [7:0] rate,
                                         input logic [7:0] id);
    logic [127:0] t;
    t[7:0]   = com;
    t[15:8]  = link;
    t[23:16] = lane;
    t[31:24] = 8'h18;
    t[39:32] = rate;
    t[47:40] = 8'h00;
    for (int k = 6; k < 16; k++) t[8*k +: 8] = id;
    return t;
  endfunction

  logic [127:0] ts1_a, ts1_b, ts2_a, bad_com, mixed;

  initial begin
    ts1_a   = mk_ts(8'hBC, 8'hF7, 8'h00, 8'h02, 8'h4A);
    ts1_b   = mk_ts(8'hBC, 8'hF7, 8'h01, 8'h02, 8'h4A);
    ts2_a   = mk_ts(8'hBC, 8'hF7, 8'h00, 8'h02, 8'h45);
    bad_com = mk_ts(8'h1C, 8'h55, 8'h00, 8'h02, 8'h4A);
    mixed   = ts1_a;
    mixed[79:72] = 8'h45;

    rst = 1'b0; ts_i = '0; ts_i_vld = 1'b0; clr = 1'b0; expect_ts2 = 1'b0;
    idle(3);
    check("rst_rcv", 32'(rcv_enough), 32'd0);
    check("rst_cnt", 32'(cons_cnt), 32'd0);
    check("rst_ts2", 32'(ts_is_ts2), 32'd0);
    check("rst_link", 32'(rx_link_num), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    rst = 1'b1;
    idle(2);

    // 8 identical TS1s, one every 64 clk
    for (int i = 1; i <= 8; i++) begin
      send(ts1_a);
      check($sformatf("t1_cnt%0d", i), 32'(cons_cnt), 32'(i));
      check($sformatf("t1_rcv%0d", i), 32'(rcv_enough), (i == 8) ? 32'd1 : 32'd0);
      if (i < 8) idle(63);
    end
    check("t1_rate", 32'(rx_rate), 32'h02);
    check("t1_link", 32'(rx_link_num), 32'hF7);
    check("t1_ts2", 32'(ts_is_ts2), 32'd0);
    pulse_clr();
    check("t1_clr_cnt", 32'(cons_cnt), 32'd0);
    check("t1_clr_rcv", 32'(rcv_enough), 32'd0);

    // Lane number changes from the 5th TS onward: count restarts at TS5
    for (int i = 1; i <= 12; i++) begin
      send((i >= 5) ? ts1_b : ts1_a);
      check($sformatf("t2_cnt%0d", i), 32'(cons_cnt), (i < 5) ? 32'(i) : 32'(i - 4));
      check($sformatf("t2_rcv%0d", i), 32'(rcv_enough), (i == 12) ? 32'd1 : 32'd0);
      idle(7);
    end
    check("t2_lane", 32'(rx_lane_num), 32'h01);
    pulse_clr();

    // Malformed COM breaks lock; fields not updated by a malformed TS
    for (int i = 1; i <= 4; i++) send(ts1_a);
    check("t3_cnt4", 32'(cons_cnt), 32'd4);
    send(bad_com);
    check("t3_bad_cnt", 32'(cons_cnt), 32'd0);
    check("t3_bad_link", 32'(rx_link_num), 32'hF7);
    check("t3_err1", 32'(err_cnt), (ERR_EN != 0) ? 32'd1 : 32'd0);
    send(ts1_a);
    send(ts1_a);
    check("t3_relock", 32'(cons_cnt), 32'd2);
    send(mixed);
    check("t3_mix_cnt", 32'(cons_cnt), 32'd0);
    check("t3_err2", 32'(err_cnt), (ERR_EN != 0) ? 32'd2 : 32'd0);
    // Good but unexpected TS2 while locked on TS1
    send(ts1_a);
    send(ts1_a);
    send(ts2_a);
    check("t3_unexp_cnt", 32'(cons_cnt), 32'd0);
    check("t3_unexp_ts2", 32'(ts_is_ts2), 32'd1);

    // Gap timeout: count held for 255 cycles, discarded at cycle 256
    for (int i = 1; i <= 3; i++) send(ts1_a);
    check("t4_cnt3", 32'(cons_cnt), 32'd3);
    idle(255);
    check("t4_hold255", 32'(cons_cnt), 32'd3);
    idle(1);
    check("t4_exp256", 32'(cons_cnt), 32'd0);
    idle(44);
    send(ts1_a);
    check("t4_restart", 32'(cons_cnt), 32'd1);

    // Reach DONE, fields keep updating there, count holds
    for (int i = 2; i <= 8; i++) send(ts1_a);
    check("t5_rcv", 32'(rcv_enough), 32'd1);
    send(mk_ts(8'hBC, 8'hF7, 8'h00, 8'h03, 8'h4A));
    check("t5_done_rate", 32'(rx_rate), 32'h03);
    check("t5_done_cnt", 32'(cons_cnt), 32'd8);
    check("t5_done_rcv", 32'(rcv_enough), 32'd1);
    // clr with coincident TS: TS dropped, switch to counting TS2
    ts_i       = mk_ts(8'hBC, 8'h33, 8'h00, 8'h02, 8'h4A);
    ts_i_vld   = 1'b1;
    clr        = 1'b1;
    expect_ts2 = 1'b1;
    tick();
    ts_i_vld = 1'b0;
    clr      = 1'b0;
    check("t5_clr_rcv", 32'(rcv_enough), 32'd0);
    check("t5_clr_cnt", 32'(cons_cnt), 32'd0);
    check("t5_clr_link", 32'(rx_link_num), 32'hF7);
    for (int i = 1; i <= 8; i++) begin
      send(ts2_a);
      check($sformatf("t5_cnt%0d", i), 32'(cons_cnt), 32'(i));
      idle(3);
    end
    check("t5_rcv2", 32'(rcv_enough), 32'd1);
    check("t5_ts2", 32'(ts_is_ts2), 32'd1);

    // Asynchronous reset mid-LOCK
    expect_ts2 = 1'b0;
    pulse_clr();
    for (int i = 1; i <= 5; i++) send(ts1_a);
    check("t6_cnt5", 32'(cons_cnt), 32'd5);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_cnt", 32'(cons_cnt), 32'd0);
    check("t6_async_link", 32'(rx_link_num), 32'd0);
    check("t6_async_rate", 32'(rx_rate), 32'd0);
    check("t6_async_err", 32'(err_cnt), 32'd0);
    idle(2);
    rst = 1'b1;
    idle(1);
    send(ts1_a);
    check("t6_restart", 32'(cons_cnt), 32'd1);
    check("t6_rcv", 32'(rcv_enough), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ts_rx_chk.md
Name: ts_rx_chk

Overview:
- Per-lane receive-side Training Sequence checker. It sits between a lane's inbound TS bus (laneN_ts_i / laneN_ts_i_vld, one 128-bit TS every 4-64 clk) and core_fsm.
- Validates each TS, classifies it as TS1 or TS2, and counts consecutive identical TSs.
- Flags "received enough" to core_fsm for Polling/Config exit decisions and exposes the decoded fields of the last good TS.
- One instance per lane.

Parameters:
- CNT_W, 5, width of the consecutive counters (saturating).
- RCV_THRESH, 8, consecutive identical TSs required to assert rcv_enough.
- GAP_TO, 256, clk cycles without ts_i_vld (while LOCK) before the count is discarded.

Ports:
- clk  in  1  1 GHz system clock
- rst  in  1  asynchronous, active-low reset
- ts_i  in  128  inbound TS; symbol k at [8k+7:8k]
- ts_i_vld  in  1  single-cycle strobe; ts_i is valid this cycle
- clr  in  1  core_fsm state-change pulse; flushes the count and returns to HUNT
- expect_ts2  in  1  0: count TS1s, 1: count TS2s
- rcv_enough  out  1  RCV_THRESH consecutive identical expected TSs seen; sticky until clr
- cons_cnt  out  CNT_W  current consecutive count
- ts_is_ts2  out  1  type of the last good TS
- rx_link_num  out  8  symbol 1 of the last good TS
- rx_lane_num  out  8  symbol 2 of the last good TS
- rx_rate  out  8  symbol 4 of the last good TS
- rx_ctrl  out  8  symbol 5 of the last good TS
- err_cnt  out  8  malformed-TS count (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): every output is 0; FSM=HUNT; the previous-TS register is 0.
- Good TS:
  - sym0 must equal 8'hBC.
  - sym6..sym15 must all equal 8'h4A (TS1) or all equal 8'h45 (TS2).
  - Anything else is malformed; a TS with mixed identifiers is malformed.
- Expected TS: a good TS whose type matches expect_ts2.
- Identical TS: symbols 1-5 equal those of the previously accepted expected TS.
- FSM (registered, one ts_i_vld processed per cycle; outputs update the cycle after ts_i_vld, latency 1):
  - HUNT:
    - Expected TS -> capture fields, cons_cnt=1, go to LOCK.
    - Any other TS -> stay; fields update on any good TS.
  - LOCK, on an expected identical TS:
    - cons_cnt increments, saturating at 2^CNT_W-1.
    - When cons_cnt reaches RCV_THRESH -> go to DONE and assert rcv_enough in the same registered update.
  - LOCK, on an expected non-identical TS: cons_cnt=1, fields recaptured, stay in LOCK.
  - LOCK, on a good but unexpected TS, or a malformed TS: cons_cnt=0, go to HUNT.
  - LOCK gap timer:
    - A GAP_TO-cycle timer restarts on every ts_i_vld.
    - On expiry, cons_cnt=0 and the FSM goes to HUNT.
  - DONE:
    - rcv_enough=1 and cons_cnt holds.
    - Fields keep updating on good TSs.
    - Leaves DONE only on clr.
- clr:
  - Next cycle: FSM=HUNT, cons_cnt=0, rcv_enough=0, gap timer cleared. Fields and err_cnt are kept.
  - clr with a simultaneous ts_i_vld: clr wins and that TS is dropped.
- A change of expect_ts2 without clr takes effect on the next TS. core_fsm always pulses clr with the change.
- ts_i_vld on consecutive cycles is legal; each TS is processed.
- No backpressure; a TS can never be dropped except by clr.

Optional Feature:
- Macro TS_RX_ERR_CNT_EN.
  - Defined: err_cnt increments (saturating at 255) on every malformed TS. It is not cleared by clr, only by reset.
  - Undefined: err_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Shared package ltssm_pkg holds:
  - COM_SYM=8'hBC, TS1_ID=8'h4A, TS2_ID=8'h45
  - Symbol index constants
  - The rx FSM state enum {HUNT, LOCK, DONE}
- ts_gen reuses the same constants.
- One sub-module, ts_rx_decode: purely combinational; outputs is_good, is_ts2 and the field extraction from ts_i.
- Sequencing stays in ts_rx_chk.

Test Plan:
- 8 identical good TS1s (link=8'hF7, lane=8'h00, rate=8'h02) with expect_ts2=0, one every 64 clk -> cons_cnt 1..8; rcv_enough rises the cycle after the 8th vld; rx_rate=8'h02.
- Same stream, but the 5th TS has rx_lane_num=8'h01 -> cons_cnt drops to 1 at TS5; rcv_enough rises after TS12.
- 4 TS1s, then a TS with sym0=8'h1C -> cons_cnt=0, FSM=HUNT; with TS_RX_ERR_CNT_EN, err_cnt=1, otherwise 0.
- 3 TS1s, then no vld for 300 clk (GAP_TO=256) -> cons_cnt=0 at cycle 256 after the last vld; the next TS1 gives cons_cnt=1.
- In DONE, clr pulse coinciding with ts_i_vld, expect_ts2 switches to 1, then 8 TS2s -> rcv_enough=0 and cons_cnt=0 the cycle after clr; the coincident TS is ignored; rcv_enough=1 after the 8th TS2; ts_is_ts2=1.
- Assert rst low mid-LOCK (cons_cnt=5), asynchronously between clk edges -> all outputs read 0 immediately, before the next clk edge; after release, counting restarts from HUNT.
